// File: rtl/inst_fetch.sv
// Instruction fetch stage: in-order word reads, small {pc, instr} FIFO, decode handshake.
// Optional ebreak halt enabled by defining INST_FETCH_EBREAK_HALT_EN.
module inst_fetch #(
  parameter logic [31:0] ResetAddr = 32'h0000_0000,
  parameter int          Depth     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        instmem_ready_i,
  output logic        instmem_valid_o,
  output logic [31:0] instmem_addr_o,
  output logic [31:0] instmem_wdata_o,
  output logic [3:0]  instmem_wmask_o,
  input  logic [31:0] instmem_rdata_i,
  input  logic        instmem_rvalid_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_pc_o,
  output logic [31:0] inst_data_o,
  output logic        halted_o
);

  localparam int CW = $clog2(Depth + 1);
  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [31:0] Ebreak = 32'h0010_0073;

  logic          started_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   rsp_pc_q;
  logic [CW-1:0] outst_q;
  logic [CW-1:0] drop_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [31:0]   pc_mem   [Depth];
  logic [31:0]   data_mem [Depth];

  logic          halted;
  logic          pop;
  logic          push;
  logic          accept;
  logic          rsp;
  logic          issue_ok;
  logic [CW:0]   inflight;
  logic [31:0]   redir_pc;
  logic          unused_pc_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign unused_pc_bits = ^redirect_pc_i[1:0];
  assign redir_pc = {redirect_pc_i[31:2], 2'b00};

  assign inst_valid_o = (count_q != '0);
  assign inst_pc_o    = pc_mem[rd_ptr_q];
  assign inst_data_o  = data_mem[rd_ptr_q];
  assign pop          = inst_valid_o & inst_ready_i;

  // A same-cycle pop frees a slot, so one word per cycle is sustained.
  assign inflight = {1'b0, outst_q} + {1'b0, count_q}
                  - {{CW{1'b0}}, pop};
  assign issue_ok = inflight < (CW + 1)'(Depth);

  assign instmem_valid_o = started_q & ~redirect_i
                         & ~halted & issue_ok;
  assign instmem_addr_o  = fetch_pc_q;
  assign instmem_wdata_o = 32'h0;
  assign instmem_wmask_o = 4'h0;

  assign accept = instmem_valid_o & instmem_ready_i;
  // Responses with nothing outstanding are stale (e.g. across reset).
  assign rsp    = instmem_rvalid_i & (outst_q != '0);
  assign push   = rsp & ~redirect_i & (drop_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      started_q  <= 1'b0;
      fetch_pc_q <= ResetAddr;
      rsp_pc_q   <= ResetAddr;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      started_q <= 1'b1;
      if (redirect_i) begin
        fetch_pc_q <= redir_pc;
        rsp_pc_q   <= redir_pc;
        outst_q    <= outst_q - CW'(rsp);
        drop_q     <= outst_q - CW'(rsp);
      end else begin
        if (accept)
          fetch_pc_q <= fetch_pc_q + 32'd4;
        if (push)
          rsp_pc_q <= rsp_pc_q + 32'd4;
        if (rsp && drop_q != '0)
          drop_q <= drop_q - CW'(1);
        outst_q <= outst_q + CW'(accept) - CW'(rsp);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= rsp_pc_q;
      data_mem[wr_ptr_q] <= instmem_rdata_i;
    end
  end

`ifdef INST_FETCH_EBREAK_HALT_EN
  logic halted_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      halted_q <= 1'b0;
    else if (redirect_i)
      halted_q <= 1'b0;
    else if (push && instmem_rdata_i == Ebreak)
      halted_q <= 1'b1;
  end

  assign halted = halted_q;
`else
  logic unused_ebreak;

  assign unused_ebreak = ^Ebreak;
  assign halted = 1'b0;
`endif

  assign halted_o = halted;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch with a latency-1 (optionally 2) RAM model.
// Optional ebreak scenario follows INST_FETCH_EBREAK_HALT_EN.
module tb_inst_fetch;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_ready;
  logic        inst_ready;
  logic        lat2;

  logic        instmem_valid_o;
  logic [31:0] instmem_addr_o;
  logic [31:0] instmem_wdata_o;
  logic [3:0]  instmem_wmask_o;
  logic [31:0] instmem_rdata_i;
  logic        instmem_rvalid_i;
  logic        inst_valid_o;
  logic [31:0] inst_pc_o;
  logic [31:0] inst_data_o;
  logic        halted_o;

  logic [31:0] mem [256];
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [31:0] d1 = '0, d2 = '0;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] got_pc[$];
  logic [31:0] got_dat[$];
  int          got_cyc[$];
  logic [31:0] req_q[$];
  int          req_cyc[$];

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .redirect_i      (redirect),
    .redirect_pc_i   (redirect_pc),
    .instmem_ready_i (mem_ready),
    .instmem_valid_o (instmem_valid_o),
    .instmem_addr_o  (instmem_addr_o),
    .instmem_wdata_o (instmem_wdata_o),
    .instmem_wmask_o (instmem_wmask_o),
    .instmem_rdata_i (instmem_rdata_i),
    .instmem_rvalid_i(instmem_rvalid_i),
    .inst_valid_o    (inst_valid_o),
    .inst_ready_i    (inst_ready),
    .inst_pc_o       (inst_pc_o),
    .inst_data_o     (inst_data_o),
    .halted_o        (halted_o)
  );

  always @(posedge clk) begin
    v1 <= instmem_valid_o & mem_ready;
    d1 <= mem[instmem_addr_o[9:2]];
    v2 <= v1;
    d2 <= d1;
  end

  assign instmem_rvalid_i = lat2 ? v2 : v1;
  assign instmem_rdata_i  = lat2 ? d2 : d1;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (inst_valid_o && inst_ready) begin
        got_pc.push_back(inst_pc_o);
        got_dat.push_back(inst_data_o);
        got_cyc.push_back(cyc);
      end
      if (instmem_valid_o && mem_ready) begin
        req_q.push_back(instmem_addr_o);
        req_cyc.push_back(cyc);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    got_pc.delete();
    got_dat.delete();
    got_cyc.delete();
    req_q.delete();
    req_cyc.delete();
  endtask

  task automatic do_reset(input logic l2);
    @(negedge clk);
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    mem_ready = 1'b1;
    inst_ready = 1'b1;
    lat2 = l2;
    cycles(2);
    clear_logs();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    lat2 = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    mem_ready = 1'b1;
    inst_ready = 1'b1;
    #1;
    checks++;
    if (instmem_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_valid got %b want 0", instmem_valid_o);
    end
    checks++;
    if (inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_inst_valid got %b want 0", inst_valid_o);
    end
    checks++;
    if (halted_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_halted got %b want 0", halted_o);
    end
    cycles(2);
    clear_logs();
    rst = 1'b0;
    #1;
    checks++;
    if (instmem_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL first_cycle_req got %b want 0", instmem_valid_o);
    end
    @(negedge clk);
    checks++;
    if (instmem_valid_o !== 1'b1 || instmem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL first_req got %b/%h want 1/00000000",
               instmem_valid_o, instmem_addr_o);
    end
    checks++;
    if (instmem_wdata_o !== 32'h0 || instmem_wmask_o !== 4'h0) begin
      errors++;
      $display("FAIL wr_consts got %h/%h want 0/0",
               instmem_wdata_o, instmem_wmask_o);
    end
  endtask

  task automatic test_stream();
    do_reset(1'b0);
    cycles(10);
    checks++;
    if (got_pc.size() < 4 || req_q.size() < 1) begin
      errors++;
      $display("FAIL stream_count got %0d want >=4", got_pc.size());
      return;
    end
    checks++;
    if (got_cyc[0] - req_cyc[0] != 2) begin
      errors++;
      $display("FAIL stream_latency got %0d want 2",
               got_cyc[0] - req_cyc[0]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_pc[i] !== 32'(4 * i) || got_dat[i] !== mem[i]
          || got_cyc[i] != got_cyc[0] + i) begin
        errors++;
        $display("FAIL stream_%0d got %h/%h@%0d want %h/%h@%0d", i,
                 got_pc[i], got_dat[i], got_cyc[i],
                 32'(4 * i), mem[i], got_cyc[0] + i);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    inst_ready = 1'b0;
    cycles(6);
    checks++;
    if (instmem_valid_o !== 1'b0 || req_q.size() != 2) begin
      errors++;
      $display("FAIL full_gate got %b/%0d want 0/2",
               instmem_valid_o, req_q.size());
    end
    checks++;
    if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h0
        || inst_data_o !== mem[0]) begin
      errors++;
      $display("FAIL full_head got %b/%h/%h want 1/0/%h",
               inst_valid_o, inst_pc_o, inst_data_o, mem[0]);
    end
    inst_ready = 1'b1;
    cycles(8);
    checks++;
    if (got_pc.size() < 3) begin
      errors++;
      $display("FAIL release_count got %0d want >=3", got_pc.size());
      return;
    end
    for (int i = 0; i < got_pc.size(); i++) begin
      checks++;
      if (got_pc[i] !== 32'(4 * i) || got_dat[i] !== mem[i]) begin
        errors++;
        $display("FAIL release_%0d got %h/%h want %h/%h", i,
                 got_pc[i], got_dat[i], 32'(4 * i), mem[i]);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    cycles(2);
    redirect = 1'b1;
    redirect_pc = 32'h42;
    #1;
    checks++;
    if (instmem_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL redir_noreq got %b want 0", instmem_valid_o);
    end
    @(negedge clk);
    redirect = 1'b0;
    clear_logs();
    #1;
    checks++;
    if (inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush got %b want 0", inst_valid_o);
    end
    cycles(6);
    checks++;
    if (got_pc.size() < 2 || req_q.size() < 1) begin
      errors++;
      $display("FAIL redir_count got %0d want >=2", got_pc.size());
      return;
    end
    checks++;
    if (req_q[0] !== 32'h40 || got_pc[0] !== 32'h40
        || got_dat[0] !== mem[16]) begin
      errors++;
      $display("FAIL redir_first got %h/%h/%h want 40/40/%h",
               req_q[0], got_pc[0], got_dat[0], mem[16]);
    end
    checks++;
    if (got_pc[1] !== 32'h44 || got_dat[1] !== mem[17]) begin
      errors++;
      $display("FAIL redir_second got %h/%h want 44/%h",
               got_pc[1], got_dat[1], mem[17]);
    end
  endtask

  task automatic test_redirect_drop();
    do_reset(1'b1);
    cycles(2);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect = 1'b0;
    clear_logs();
    cycles(10);
    checks++;
    if (got_pc.size() < 2) begin
      errors++;
      $display("FAIL drop_count got %0d want >=2", got_pc.size());
      return;
    end
    checks++;
    if (got_pc[0] !== 32'h40 || got_dat[0] !== mem[16]) begin
      errors++;
      $display("FAIL drop_first got %h/%h want 40/%h",
               got_pc[0], got_dat[0], mem[16]);
    end
    checks++;
    if (got_pc[1] !== 32'h44 || got_dat[1] !== mem[17]) begin
      errors++;
      $display("FAIL drop_second got %h/%h want 44/%h",
               got_pc[1], got_dat[1], mem[17]);
    end
  endtask

  task automatic test_mem_stall();
    do_reset(1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (instmem_valid_o !== 1'b1 || instmem_addr_o !== 32'h0
          || inst_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d got %b/%h/%b want 1/0/0", i,
                 instmem_valid_o, instmem_addr_o, inst_valid_o);
      end
    end
    mem_ready = 1'b1;
    cycles(5);
    checks++;
    if (got_pc.size() < 1 || req_q.size() < 2) begin
      errors++;
      $display("FAIL stall_count got %0d want >=1", got_pc.size());
      return;
    end
    checks++;
    if (got_pc[0] !== 32'h0 || got_dat[0] !== mem[0]
        || req_q[0] !== 32'h0 || req_q[1] !== 32'h4) begin
      errors++;
      $display("FAIL stall_resume got %h/%h/%h/%h want 0/%h/0/4",
               got_pc[0], got_dat[0], req_q[0], req_q[1], mem[0]);
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b0);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect = 1'b0;
    clear_logs();
    cycles(6);
    checks++;
    if (got_pc.size() < 2 || req_q.size() < 2) begin
      errors++;
      $display("FAIL wrap_count got %0d want >=2", got_pc.size());
      return;
    end
    checks++;
    if (req_q[0] !== 32'hFFFF_FFFC || req_q[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_req got %h/%h want fffffffc/0",
               req_q[0], req_q[1]);
    end
    checks++;
    if (got_pc[0] !== 32'hFFFF_FFFC || got_dat[0] !== mem[255]
        || got_pc[1] !== 32'h0 || got_dat[1] !== mem[0]) begin
      errors++;
      $display("FAIL wrap_inst got %h/%h,%h/%h want fffffffc/%h,0/%h",
               got_pc[0], got_dat[0], got_pc[1], got_dat[1],
               mem[255], mem[0]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    cycles(3);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect_pc = 32'h204;
    @(negedge clk);
    redirect = 1'b0;
    clear_logs();
    #1;
    checks++;
    if (inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_flush got %b want 0", inst_valid_o);
    end
    cycles(6);
    checks++;
    if (got_pc.size() < 1 || req_q.size() < 1) begin
      errors++;
      $display("FAIL b2b_count got %0d want >=1", got_pc.size());
      return;
    end
    checks++;
    if (req_q[0] !== 32'h204 || got_pc[0] !== 32'h204
        || got_dat[0] !== mem[129]) begin
      errors++;
      $display("FAIL b2b_first got %h/%h/%h want 204/204/%h",
               req_q[0], got_pc[0], got_dat[0], mem[129]);
    end
  endtask

  task automatic test_ebreak();
    mem[2] = EBREAK;
    do_reset(1'b0);
    cycles(10);
    checks++;
    if (got_pc.size() < 3) begin
      errors++;
      $display("FAIL ebreak_count got %0d want >=3", got_pc.size());
      mem[2] = 32'hC0DE_0002;
      return;
    end
    checks++;
    if (got_pc[2] !== 32'h8 || got_dat[2] !== EBREAK) begin
      errors++;
      $display("FAIL ebreak_inst got %h/%h want 8/%h",
               got_pc[2], got_dat[2], EBREAK);
    end
`ifdef INST_FETCH_EBREAK_HALT_EN
    checks++;
    if (halted_o !== 1'b1 || instmem_valid_o !== 1'b0
        || req_q.size() != 4 || got_pc.size() != 4) begin
      errors++;
      $display("FAIL halt_state got %b/%b/%0d/%0d want 1/0/4/4",
               halted_o, instmem_valid_o, req_q.size(), got_pc.size());
    end
    redirect = 1'b1;
    redirect_pc = 32'h0;
    @(negedge clk);
    redirect = 1'b0;
    clear_logs();
    checks++;
    if (halted_o !== 1'b0 || instmem_valid_o !== 1'b1
        || instmem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL halt_clear got %b/%b/%h want 0/1/0",
               halted_o, instmem_valid_o, instmem_addr_o);
    end
    cycles(3);
    checks++;
    if (got_pc.size() < 1 || got_pc[0] !== 32'h0) begin
      errors++;
      $display("FAIL halt_resume got %0d entries want pc 0 first",
               got_pc.size());
    end
`else
    checks++;
    if (halted_o !== 1'b0 || req_q.size() <= 4) begin
      errors++;
      $display("FAIL no_halt got %b/%0d want 0/>4",
               halted_o, req_q.size());
    end
`endif
    mem[2] = 32'hC0DE_0002;
  endtask

  task automatic test_reset_inflight();
    do_reset(1'b1);
    cycles(3);
    rst = 1'b1;
    #1;
    checks++;
    if (instmem_valid_o !== 1'b0 || inst_valid_o !== 1'b0
        || halted_o !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got %b/%b/%b want 0/0/0",
               instmem_valid_o, inst_valid_o, halted_o);
    end
    @(negedge clk);
    clear_logs();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL late_rvalid got %b want 0", inst_valid_o);
    end
    cycles(10);
    checks++;
    if (got_pc.size() < 2) begin
      errors++;
      $display("FAIL post_rst_count got %0d want >=2", got_pc.size());
      return;
    end
    checks++;
    if (got_pc[0] !== 32'h0 || got_dat[0] !== mem[0]
        || got_pc[1] !== 32'h4 || got_dat[1] !== mem[1]) begin
      errors++;
      $display("FAIL post_rst got %h/%h,%h/%h want 0/%h,4/%h",
               got_pc[0], got_dat[0], got_pc[1], got_dat[1],
               mem[0], mem[1]);
    end
  endtask

  initial begin
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    mem_ready = 1'b1;
    inst_ready = 1'b1;
    lat2 = 1'b0;
    for (int i = 0; i < 256; i++)
      mem[i] = 32'hC0DE_0000 + 32'(i);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_drop();
    test_mem_stall();
    test_wrap();
    test_back_to_back();
    test_ebreak();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
